// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost monitor: verdict state encodings and tohost constants.
package tohost_monitor_pkg;

   typedef enum logic [2:0] {
      StRun     = 3'd0,
      StPass    = 3'd1,
      StFail    = 3'd2,
      StTimeout = 3'd3,
      StSyserr  = 3'd4
   } state_e;

   localparam logic [31:0] TohostPass        = 32'h1;
   localparam logic [31:0] DefaultTohostAddr = 32'h0000_1000;

endpackage

// File: rtl/tohost_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module tohost_monitor_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + Width'(1);
      end
   end

endmodule

// File: rtl/tohost_monitor.sv
// Passive riscv-tests tohost observer: decodes the end-of-test store and a watchdog into a
// sticky, registered verdict. Never drives the memory bus.
module tohost_monitor
   import tohost_monitor_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR = DefaultTohostAddr,
   parameter int unsigned TIMEOUT     = 5000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_we,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             syscall_err,
   output logic [30:0]      fail_testnum,
   output logic [CNT_W-1:0] cycles
);

   state_e state_q;
   logic   run;
   logic   hit;
   logic   hit_verdict;
   logic   wd_expire;

   assign run = (state_q == StRun);
   assign hit = mem_we && (mem_addr == TOHOST_ADDR);

   // A zero write is a hit but yields no verdict, so it must not mask the watchdog.
   assign hit_verdict = hit && ((mem_wstrb != 4'hf) || (mem_wdata != '0));
   assign wd_expire   = (TIMEOUT != 0) && (64'(cycles) == (64'(TIMEOUT) - 64'd1));

   tohost_monitor_sat_counter #(
      .Width (CNT_W)
   ) u_cycles (
      .clk (clk),
      .clr (rst),
      .en  (run && !hit_verdict && !wd_expire),
      .q   (cycles)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StRun;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         timeout      <= 1'b0;
         syscall_err  <= 1'b0;
         fail_testnum <= '0;
      end else if (run) begin
         if (hit && (mem_wstrb != 4'hf)) begin
            state_q     <= StSyserr;
            syscall_err <= 1'b1;
            done        <= 1'b1;
         end else if (hit && (mem_wdata == TohostPass)) begin
            state_q <= StPass;
            pass    <= 1'b1;
            done    <= 1'b1;
         end else if (hit && mem_wdata[0]) begin
            state_q      <= StFail;
            fail         <= 1'b1;
            done         <= 1'b1;
            fail_testnum <= mem_wdata[31:1];
         end else if (hit && (mem_wdata != '0)) begin
            state_q     <= StSyserr;
            syscall_err <= 1'b1;
            done        <= 1'b1;
         end else if (wd_expire) begin
            state_q <= StTimeout;
            timeout <= 1'b1;
            done    <= 1'b1;
         end
      end
   end

endmodule
